decode_issue_ctrl: RTL

Issue controller for the decode stage. It sequences the decode pipeline register through a fetch-to-execute valid/ready handshake. It tracks destination registers still in flight in a 32-bit scoreboard and holds fetch when a source operand is still pending. It also inserts bubbles and handles flushes. It sits between fetch and the decode register, and drives that register's load enable and bubble select.

---
 rtl/decode_issue_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/decode_issue_ctrl.sv
// Decode-stage issue controller: fetch/execute handshake, register scoreboard, bubbles and flush.
// Optional hazard stall counter enabled by defining DECODE_ISSUE_STATS_EN.
module decode_issue_ctrl #(
  parameter int unsigned NREGS = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       f_valid,
  output logic       f_ready,
  input  logic [4:0] f_rs1,
  input  logic [4:0] f_rs2,
  input  logic [4:0] f_rd,
  input  logic       f_use_rs1,
  input  logic       f_use_rs2,
  input  logic       f_wr_rd,
  output logic       x_valid,
  input  logic       x_ready,
  output logic       dec_reg_en,
  output logic       dec_reg_bubble,
  input  logic       flush,
  input  logic       wb_valid,
  input  logic [4:0] wb_rd
`ifdef DECODE_ISSUE_STATS_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StFull  = 2'd1,
    StFlush = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [NREGS-1:0] pending_q, pending_d;
  logic [4:0]       d_rd_q;
  logic             d_wr_q;

  logic held_wr, busy_rs1, busy_rs2, hazard, issue, accept;

  // The instruction sitting in decode counts as in flight for its own rd.
  assign held_wr  = (state_q == StFull) && d_wr_q;
  assign busy_rs1 = (f_rs1 != 5'd0) && (pending_q[f_rs1] || (held_wr && (d_rd_q == f_rs1)));
  assign busy_rs2 = (f_rs2 != 5'd0) && (pending_q[f_rs2] || (held_wr && (d_rd_q == f_rs2)));
  assign hazard   = f_valid && ((f_use_rs1 && busy_rs1) || (f_use_rs2 && busy_rs2));

  assign x_valid = (state_q == StFull) && !flush;
  assign f_ready = rst_n && !flush && (state_q != StFlush) && !hazard &&
                   ((state_q == StEmpty) || x_ready);
  assign issue   = x_valid && x_ready;
  assign accept  = f_valid && f_ready;

  always_comb begin
    state_d        = state_q;
    dec_reg_en     = 1'b0;
    dec_reg_bubble = 1'b0;
    if (!rst_n) begin
      state_d = StEmpty;
    end else if (flush) begin
      dec_reg_en     = 1'b1;
      dec_reg_bubble = 1'b1;
      state_d        = StFlush;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            dec_reg_en = 1'b1;
            state_d    = StFull;
          end
        end
        StFull: begin
          if (accept) begin
            dec_reg_en = 1'b1;
            state_d    = StFull;
          end else if (x_ready) begin
            dec_reg_en     = 1'b1;
            dec_reg_bubble = 1'b1;
            state_d        = StEmpty;
          end
        end
        StFlush: state_d = StEmpty;
        default: state_d = StEmpty;
      endcase
    end
  end

  // Set after clear so a newer writer wins over a same-cycle retirement.
  always_comb begin
    pending_d = pending_q;
    if (wb_valid && (wb_rd != 5'd0)) begin
      pending_d[wb_rd] = 1'b0;
    end
    if (issue && d_wr_q && (d_rd_q != 5'd0)) begin
      pending_d[d_rd_q] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StEmpty;
      pending_q <= '0;
      d_rd_q    <= 5'd0;
      d_wr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      if (dec_reg_en && !dec_reg_bubble) begin
        d_rd_q <= f_rd;
        d_wr_q <= f_wr_rd;
      end else if (dec_reg_en) begin
        d_wr_q <= 1'b0;
      end
    end
  end

`ifdef DECODE_ISSUE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 16'd0;
    end else if (hazard && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
